// File: rtl/e_acc_check_n.sv
// Column checksum checker for the ABFT datapath: counts accumulator beats, waits for
// the column sums to settle, then compares each column against a captured reference.

module e_acc_check_lane #(
  parameter int zBits = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [zBits-1:0] e_acc,
  input  logic [zBits-1:0] ref_in,
  output logic             mismatch
);
  logic [zBits-1:0] ref_q;

  always_ff @(posedge clk) begin
    if (rst || clr)  ref_q <= '0;
    else if (load)   ref_q <= ref_in;
  end

  assign mismatch = (e_acc != ref_q);
endmodule

module e_acc_check_n #(
  parameter int arraySize    = 4,
  parameter int addressWidth = 3,
  parameter int zBits        = 12,
  parameter int settleCycles = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    interrupt,
  input  logic                    valid,
  input  logic [zBits-1:0]        e_acc_0,
  input  logic [zBits-1:0]        e_acc_1,
  input  logic [zBits-1:0]        e_acc_2,
  input  logic [zBits-1:0]        e_acc_3,
  input  logic [zBits-1:0]        ref_0,
  input  logic [zBits-1:0]        ref_1,
  input  logic [zBits-1:0]        ref_2,
  input  logic [zBits-1:0]        ref_3,
  input  logic                    ref_valid,
  output logic                    done,
  output logic                    error,
  output logic [arraySize-1:0]    error_mask,
  output logic [addressWidth-1:0] error_col,
  output logic [addressWidth-1:0] error_count
);
  localparam int AW = addressWidth;
  localparam int CW = (arraySize > 1) ? $clog2(arraySize) : 1;
  localparam int SW = (settleCycles > 1) ? $clog2(settleCycles) : 1;

  typedef enum logic [2:0] {ACCUM, SETTLE, WAIT_REF, COMPARE, DONE} state_t;

  state_t                           state, state_n;
  logic [AW-1:0]                    beat_cnt;
  logic [SW-1:0]                    settle_cnt;
  logic [AW-1:0]                    col;
  logic                             ref_captured;
  logic                             cap_now;
  logic                             ref_ok;
  logic [CW-1:0]                    col_idx;
  logic [arraySize-1:0][zBits-1:0]  e_acc_v;
  logic [arraySize-1:0][zBits-1:0]  ref_v;
  logic [arraySize-1:0]             mismatch;

  assign e_acc_v = {e_acc_3, e_acc_2, e_acc_1, e_acc_0};
  assign ref_v   = {ref_3, ref_2, ref_1, ref_0};
  assign col_idx = col[CW-1:0];

  // Only the first ref_valid of a run is taken; interrupt discards a same-cycle pulse.
  assign cap_now = ref_valid && !ref_captured && (state != DONE) && !interrupt;
  assign ref_ok  = ref_captured || cap_now;

  genvar g;
  generate
    for (g = 0; g < arraySize; g++) begin : g_lane
      e_acc_check_lane #(.zBits(zBits)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .clr      (interrupt),
        .load     (cap_now),
        .e_acc    (e_acc_v[g]),
        .ref_in   (ref_v[g]),
        .mismatch (mismatch[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ACCUM:    if (valid && beat_cnt == AW'(arraySize-1)) state_n = SETTLE;
      SETTLE:   if (settle_cnt == SW'(settleCycles-1))     state_n = ref_ok ? COMPARE : WAIT_REF;
      WAIT_REF: if (ref_ok)                                state_n = COMPARE;
      COMPARE:  if (col == AW'(arraySize-1))               state_n = DONE;
      DONE:     state_n = DONE;
      default:  state_n = ACCUM;
    endcase
    if (interrupt) state_n = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst || interrupt) begin
      beat_cnt     <= '0;
      settle_cnt   <= '0;
      col          <= '0;
      ref_captured <= 1'b0;
      error_mask   <= '0;
      error_col    <= '0;
      error_count  <= '0;
      done         <= 1'b0;
    end else begin
      if (cap_now) ref_captured <= 1'b1;
      case (state)
        ACCUM: begin
          settle_cnt <= '0;
          if (valid) beat_cnt <= beat_cnt + 1'b1;
        end
        SETTLE: settle_cnt <= settle_cnt + 1'b1;
        COMPARE: begin
          if (mismatch[col_idx]) begin
            error_mask[col_idx] <= 1'b1;
            error_count         <= error_count + 1'b1;
            if (error_count == '0) error_col <= col;
          end
          col <= col + 1'b1;
          if (col == AW'(arraySize-1)) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign error = |error_mask;
endmodule

// File: tb/tb_e_acc_check_n.sv
// Scoreboard bench for e_acc_check_n: expected results queued at stimulus, checked when done rises.

module tb_e_acc_check_n;
  localparam int AS = 4, AW = 3, ZB = 12;

  logic clk = 1'b0;
  logic rst, interrupt, valid, ref_valid;
  logic [ZB-1:0] e_acc_0, e_acc_1, e_acc_2, e_acc_3;
  logic [ZB-1:0] ref_0, ref_1, ref_2, ref_3;
  logic done, error;
  logic [AS-1:0] error_mask;
  logic [AW-1:0] error_col, error_count;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] col;
    logic [2:0] count;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t m_e;
  logic done_q = 1'b0;

  typedef logic [3:0][ZB-1:0] refs_t;
  refs_t r_ok, r_single, r_double, r_extra, r_bad0;
  int t;

  e_acc_check_n dut (
    .clk(clk), .rst(rst), .interrupt(interrupt), .valid(valid),
    .e_acc_0(e_acc_0), .e_acc_1(e_acc_1), .e_acc_2(e_acc_2), .e_acc_3(e_acc_3),
    .ref_0(ref_0), .ref_1(ref_1), .ref_2(ref_2), .ref_3(ref_3), .ref_valid(ref_valid),
    .done(done), .error(error), .error_mask(error_mask),
    .error_col(error_col), .error_count(error_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_refs(input refs_t r);
    ref_0 = r[0]; ref_1 = r[1]; ref_2 = r[2]; ref_3 = r[3];
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_mask"},  error_mask, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_count"}, error_count, 0);
    chk({tag, "_col"},   error_col, 0);
  endtask

  // Offsets are relative to T, the cycle of the 4th beat; -100 disables an event.
  task automatic run(input refs_t r1, input int r1_off, input refs_t r2, input int r2_off,
                     input int nbeats, input int intr_off, input int rst_off, input int len);
    for (int k = 0; k < len; k++) begin
      valid     = (k < nbeats);
      interrupt = (k - 3 == intr_off);
      rst       = (k - 3 == rst_off);
      ref_valid = 1'b0;
      set_refs({4{12'hABC}});
      if (k - 3 == r1_off)      begin ref_valid = 1'b1; set_refs(r1); end
      else if (k - 3 == r2_off) begin ref_valid = 1'b1; set_refs(r2); end
      tick();
      if (k - 3 == intr_off) chk_cleared("intr");
      if (k - 3 == rst_off)  chk_cleared("rst");
    end
    valid = 1'b0; ref_valid = 1'b0; interrupt = 1'b0; rst = 1'b0;
  endtask

  task automatic intr_pulse();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    chk_cleared("restart");
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        m_e = sb.pop_front();
        chk("done_cycle", cyc, m_e.cyc);
        chk("error_mask", error_mask, m_e.mask);
        chk("error_col", error_col, m_e.col);
        chk("error_count", error_count, m_e.count);
        chk("error", error, |m_e.mask);
      end
    end
    done_q <= done;
  end

  initial begin
    r_ok     = {12'd4, 12'd4, 12'd4, 12'd4};
    r_single = {12'd4, 12'd5, 12'd4, 12'd4};
    r_double = {12'd9, 12'd4, 12'd3, 12'd4};
    r_extra  = {12'd4, 12'd7, 12'd4, 12'd4};
    r_bad0   = {12'd4, 12'd4, 12'd4, 12'd6};
    rst = 1'b1; interrupt = 1'b0; valid = 1'b0; ref_valid = 1'b0;
    e_acc_0 = 12'd4; e_acc_1 = 12'd4; e_acc_2 = 12'd4; e_acc_3 = 12'd4;
    set_refs('0);
    tick(); tick(); tick();
    chk_cleared("reset");
    rst = 1'b0;
    tick();

    // clean run, early ref
    t = cyc + 3; sb.push_back('{4'b0000, 3'd0, 3'd0, t + 6});
    run(r_ok, -2, r_ok, -100, 4, -100, -100, 14);
    intr_pulse();

    // single fault on column 2
    t = cyc + 3; sb.push_back('{4'b0100, 3'd2, 3'd1, t + 6});
    run(r_single, -2, r_ok, -100, 4, -100, -100, 14);
    intr_pulse();

    // double fault with ref arriving in WAIT_REF
    t = cyc + 3; sb.push_back('{4'b1010, 3'd1, 3'd2, t + 9});
    run(r_double, 4, r_ok, -100, 4, -100, -100, 16);
    intr_pulse();

    // interrupt mid-COMPARE after column 0 already mismatched, then a fresh clean run
    run(r_bad0, -2, r_ok, -100, 4, 3, -100, 8);
    t = cyc + 3; sb.push_back('{4'b0000, 3'd0, 3'd0, t + 6});
    run(r_ok, -2, r_ok, -100, 4, -100, -100, 14);
    intr_pulse();

    // extra beats, second ref during COMPARE, then pokes while held in DONE
    t = cyc + 3; sb.push_back('{4'b0100, 3'd2, 3'd1, t + 6});
    run(r_extra, -2, r_ok, 3, 6, -100, -100, 12);
    valid = 1'b1; ref_valid = 1'b1; set_refs(r_ok);
    tick(); tick(); tick();
    valid = 1'b0; ref_valid = 1'b0;
    chk("held_done", done, 1);
    chk("held_mask", error_mask, 4'b0100);
    chk("held_col", error_col, 2);
    chk("held_count", error_count, 1);
    intr_pulse();

    // reset during SETTLE, then only 3 beats: must not finish
    run(r_ok, -2, r_ok, -100, 4, -100, 1, 6);
    run(r_ok, -2, r_ok, -100, 3, -100, -100, 14);
    chk("no_done_3beats", done, 0);

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/e_acc_check_n.md
# e_acc_check_n

Column checksum checker that sits directly downstream of the column error accumulator (`e_n_acc_n`) in the ABFT datapath. It counts the same `valid` beats the accumulator consumes. Once all `arraySize` beats have been absorbed and the accumulator outputs have settled, it compares each accumulated column checksum against a registered reference checksum, one column per cycle. It then reports a sticky per-column error mask, the first failing column, a mismatch count and a `done` flag, all held until `interrupt`.

## Interface
- `arraySize`, 4, number of columns and of `valid` beats per run
- `addressWidth`, 3, width of beat counter, column index and error count; must satisfy 2^addressWidth > arraySize
- `zBits`, 12, width of accumulated and reference checksums
- `settleCycles`, 1, cycles waited after the last beat before comparing (≥1)
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `interrupt` in 1: run restart, same signal that clears the accumulator
- `valid` in 1: beat strobe, same signal driving the accumulator
- `e_acc_0` … `e_acc_3` in zBits each: accumulator outputs, one per column
- `ref_0` … `ref_3` in zBits each: expected column checksums
- `ref_valid` in 1: `ref_*` are valid this cycle
- `done` out 1: results final; level, held
- `error` out 1: OR of `error_mask`
- `error_mask` out arraySize: bit c set ⇔ column c mismatched
- `error_col` out addressWidth: lowest mismatching column index, 0 if none
- `error_count` out addressWidth: number of mismatching columns

## Operation
- FSM states: ACCUM, SETTLE, WAIT_REF, COMPARE, DONE. Reset state is ACCUM.
- **ACCUM**
  - `beat_cnt` increments on each cycle with `valid`=1.
  - On the beat where `beat_cnt`==arraySize-1, go to SETTLE with `settle_cnt`=0.
- **SETTLE**
  - Stays settleCycles cycles.
  - Then goes to COMPARE if the reference is captured, else to WAIT_REF.
- **WAIT_REF**
  - Waits for the reference to be captured.
  - Goes to COMPARE on the edge that captures it.
- **Reference capture**
  - In any state except DONE, `ref_valid`=1 with `ref_captured`=0 loads `ref_0..3` into internal registers and sets `ref_captured`.
  - Later `ref_valid` pulses are ignored until `interrupt`/`rst`.
- **COMPARE**
  - `col` runs 0..arraySize-1, one per cycle. The column is selected by `col`; the comparison is an exact zBits equality against the registered ref.
  - On a mismatch, at the edge ending the cycle:
    - set `error_mask[col]`
    - increment `error_count`
    - if `error_count` was 0, load `error_col` ← `col`
  - After column arraySize-1, go to DONE.
- **DONE**
  - `done`=1; all outputs are frozen.
  - `valid` and `ref_valid` are ignored.
  - Leaves only on `interrupt`/`rst`.
- **Extra beats:** `valid` beats in SETTLE/WAIT_REF/COMPARE/DONE are ignored (the accumulator also stops at arraySize).
- **`interrupt`=1 in any state:** at the next edge go to ACCUM and clear `beat_cnt`, `settle_cnt`, `col`, `ref_captured`, `error_mask`, `error_col`, `error_count`, `done`. A `valid` or `ref_valid` in the same cycle is discarded.
- **`rst` and `interrupt` together:** identical result.
- **Outputs:** all registered except `error`, which is a combinational OR of the registered mask.
- **Qualification:** `error_mask`, `error_col` and `error_count` may change during COMPARE; they are meaningful only while `done`=1.

## Timing
- **Reset values:** `done`=0, `error`=0, `error_mask`=0, `error_col`=0, `error_count`=0; state ACCUM.
- Let T be the cycle of the arraySize-th `valid` beat.
  - SETTLE occupies T+1..T+settleCycles.
  - With the ref captured by then, COMPARE occupies T+settleCycles+1 .. T+settleCycles+arraySize.
  - `done` rises at T+settleCycles+arraySize+1. With defaults this is T+6.
- **Late reference:** if `ref_valid` first arrives in WAIT_REF at cycle R, COMPARE starts at R+1 and `done` rises at R+arraySize+1.
- **Early reference:** `ref_valid` before or during the beats costs no latency.
- **Interrupt latency:** `done` and the mask fall one cycle after `interrupt`. The first `valid` beat counted is in the cycle after `interrupt` deasserts.

## Test plan
- **Clean run:** `e_*`=1 for 4 beats, so `e_acc_*`=4; ref_0..3=4 with `ref_valid` at T-2.
  - Expect `done`=1 at T+6, `error`=0, `error_mask`=0000, `error_count`=0, `error_col`=0.
- **Single fault:** as above but ref_2=5.
  - Expect `done` at T+6, `error_mask`=0100, `error_col`=2, `error_count`=1, `error`=1.
- **Double fault and late ref:** ref_1=3, ref_3=9, `ref_valid` at T+4.
  - Expect COMPARE T+5..T+8, `done` at T+9, `error_mask`=1010, `error_col`=1, `error_count`=2.
- **Interrupt mid-COMPARE:** `interrupt` at T+3.
  - Expect at T+4: `done`=0, `error_mask`=0, state ACCUM.
  - A fresh 4-beat run with a matching ref gives a clean `done` 6 cycles after its last beat.
- **Extra beats and second ref:** 6 `valid` beats, plus a second `ref_valid` with different values during COMPARE.
  - Expect `done` at T+6 counted from the 4th beat; the comparison uses the first ref; results unchanged while held in DONE.
- **Reset mid-SETTLE:** `rst` at T+1.
  - Expect all outputs at reset values at T+2; no `done` without 4 new beats.
